// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared word/block geometry and default read latency for the fill responder.
package mem_resp_pkg;
  localparam int WORD_W          = 16;
  localparam int BEATS_PER_BLOCK = 8;
  localparam int DEFAULT_LATENCY = 4;
  localparam int BEAT_W          = $clog2(BEATS_PER_BLOCK);
endpackage

// File: rtl/mem_resp_delay_line.sv
// mem_resp_delay_line: LATENCY-stage valid/payload shift pipeline with flush.
module mem_resp_delay_line
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int W       = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         busy
);
  logic [LATENCY-1:0] r_valid, w_vin;
  logic [W-1:0]       r_data [LATENCY];
  logic [W-1:0]       w_din  [LATENCY];
  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_vin[g] = in_valid;
      assign w_din[g] = in_data;
    end else begin : g_tail
      assign w_vin[g] = r_valid[g-1];
      assign w_din[g] = r_data[g-1];
    end
  end
  // payload only advances with a live beat, so the last stage holds between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_valid <= flush ? '0 : w_vin;
      for (int i = 0; i < LATENCY; i++) if (w_vin[i] && !flush) r_data[i] <= w_din[i];
    end
  end
  assign out_valid = r_valid[LATENCY-1];
  assign out_data  = r_data[LATENCY-1];
  assign busy      = |r_valid;
endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: pipelined word-array read responder with block beat tracking.
// Define MEM_RESP_ADDR_ECHO_EN to add the resp_addr echo output.
module mem_fill_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              abort,
`ifdef MEM_RESP_ADDR_ECHO_EN
  output logic [ADDR_W-1:0] resp_addr,
`endif
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              last_beat,
  output logic              busy
);
`ifdef MEM_RESP_ADDR_ECHO_EN
  localparam int PW = WORD_W + ADDR_W;
`else
  localparam int PW = WORD_W;
`endif
  logic [WORD_W-1:0] r_mem [2**(ADDR_W-1)];
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-2:0] w_word;
  logic [PW-1:0]     w_in, w_out;
  logic              w_unused;
  assign w_word   = req_addr[ADDR_W-1:1];
  assign w_unused = req_addr[0];
  // read is taken before the edge, so a same-cycle write is not visible to it
`ifdef MEM_RESP_ADDR_ECHO_EN
  assign w_in      = {req_addr, r_mem[w_word]};
  assign resp_addr = w_out[PW-1:WORD_W];
`else
  assign w_in      = r_mem[w_word];
`endif
  assign data_out  = w_out[WORD_W-1:0];
  assign last_beat = data_valid && r_beat == BEAT_W'(BEATS_PER_BLOCK - 1);
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[w_word] <= wr_data;
  end
  always_ff @(posedge clk) begin
    r_beat <= (rst || abort) ? '0 : r_beat + BEAT_W'(data_valid);
  end
  mem_resp_delay_line #(.LATENCY(LATENCY), .W(PW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_valid (req_valid),
    .in_data  (w_in),
    .out_valid(data_valid),
    .out_data (w_out),
    .busy     (busy)
  );
endmodule
